sin_cos_dco_mc: RTL and testbench

SIN_COS_DCO_MC -- requirements
Module: sin_cos_dco_mc

---
 rtl/dco_pkg.sv | 18 +
 rtl/sin_cos_rom.sv | 77 +++++++
 rtl/sin_cos_dco_mc.sv | 140 ++++++++++++++
 tb/tb_sin_cos_dco_mc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dco_pkg.sv
// Shared constants and helpers for the multi-channel sine/cosine DCO.
package dco_pkg;

    localparam int unsigned PIPE_LATENCY  = 6;
    localparam int unsigned TABLE_LATENCY = 4;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/sin_cos_rom.sv
// Quarter-wave sine/cosine lookup with a fixed four-stage pipeline.
module sin_cos_rom
    import dco_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 13,
    parameter int unsigned ADDR_WIDTH = 12
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CE,
    input  logic [ADDR_WIDTH-1:0]        ADDR,
    output logic signed [DATA_WIDTH-1:0] SIN,
    output logic signed [DATA_WIDTH-1:0] COS
);

    localparam int unsigned MAG_W   = DATA_WIDTH - 1;
    localparam int unsigned IDX_W   = ADDR_WIDTH - 1;
    localparam int unsigned QUARTER = 1 << (ADDR_WIDTH - 2);
    localparam real         HALF_PI = 1.5707963267948966;
    localparam real         PEAK    = real'((1 << (DATA_WIDTH - 1)) - 1);

    function automatic logic [MAG_W-1:0] q_sin(input int unsigned k);
        real x;
        x = $sin(HALF_PI * real'(k) / real'(QUARTER)) * PEAK;
        return MAG_W'($rtoi(x + 0.5));
    endfunction

    // Table holds QUARTER+1 points so that both 0 and the peak are exact.
    logic [MAG_W-1:0] qtable [QUARTER+1];
    for (genvar k = 0; k <= int'(QUARTER); k++) begin : g_tab
        localparam logic [MAG_W-1:0] ENTRY = q_sin(k);
        assign qtable[k] = ENTRY;
    end

    logic [1:0]            quad_c;
    logic [IDX_W-1:0]      i_fwd_c, i_rev_c;
    logic [IDX_W-1:0]      sin_idx, cos_idx;
    logic                  sin_neg1, cos_neg1, sin_neg2, cos_neg2;
    logic [MAG_W-1:0]      sin_mag, cos_mag;
    logic signed [DATA_WIDTH-1:0] sin_val, cos_val;

    assign quad_c  = ADDR[ADDR_WIDTH-1 -: 2];
    assign i_fwd_c = IDX_W'(ADDR[ADDR_WIDTH-3:0]);
    assign i_rev_c = IDX_W'(QUARTER) - i_fwd_c;

    // Stages: fold to quadrant, table read, apply sign, output register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sin_idx  <= '0;
            cos_idx  <= '0;
            sin_neg1 <= 1'b0;
            cos_neg1 <= 1'b0;
            sin_mag  <= '0;
            cos_mag  <= '0;
            sin_neg2 <= 1'b0;
            cos_neg2 <= 1'b0;
            sin_val  <= '0;
            cos_val  <= '0;
            SIN      <= '0;
            COS      <= '0;
        end else if (CE) begin
            sin_idx  <= quad_c[0] ? i_rev_c : i_fwd_c;
            cos_idx  <= quad_c[0] ? i_fwd_c : i_rev_c;
            sin_neg1 <= quad_c[1];
            cos_neg1 <= quad_c[1] ^ quad_c[0];
            sin_mag  <= qtable[sin_idx];
            cos_mag  <= qtable[cos_idx];
            sin_neg2 <= sin_neg1;
            cos_neg2 <= cos_neg1;
            sin_val  <= sin_neg2 ? -$signed({1'b0, sin_mag}) : $signed({1'b0, sin_mag});
            cos_val  <= cos_neg2 ? -$signed({1'b0, cos_mag}) : $signed({1'b0, cos_mag});
            SIN      <= sin_val;
            COS      <= cos_val;
        end
    end

endmodule

// File: rtl/sin_cos_dco_mc.sv
// Time-multiplexed multi-channel DCO: one accumulator update per slot, shared sine/cosine ROM.
module sin_cos_dco_mc
    import dco_pkg::*;
#(
    parameter  int unsigned PHASE_BITS     = 32,
    parameter  int unsigned PHASE_INC_BITS = 28,
    parameter  int unsigned DATA_WIDTH     = 13,
    parameter  int unsigned ADDR_WIDTH     = 12,
    parameter  int unsigned CHANNELS       = 4,
    parameter  int unsigned AMP_BITS       = 8,
    localparam int unsigned CH_BITS        = clog2(CHANNELS)
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic                         CE,
    input  logic [CH_BITS-1:0]           CFG_CH,
    input  logic [PHASE_INC_BITS-1:0]    CFG_INC,
    input  logic                         CFG_INC_WE,
    input  logic [AMP_BITS-1:0]          CFG_AMP,
    input  logic                         CFG_AMP_WE,
    input  logic                         SYNC,
    output logic signed [DATA_WIDTH-1:0] SIN_OUT,
    output logic signed [DATA_WIDTH-1:0] COS_OUT,
    output logic [CH_BITS-1:0]           OUT_CH,
    output logic                         OUT_VALID,
    output logic                         OUT_WRAP
);

    localparam int unsigned SUM_W  = PHASE_BITS + 1;
    localparam int unsigned VLEN   = PIPE_LATENCY - 1;
    localparam int unsigned MLEN   = TABLE_LATENCY + 1;
    localparam int unsigned PROD_W = DATA_WIDTH + AMP_BITS + 1;

    logic [PHASE_BITS-1:0]     phase    [CHANNELS];
    logic [PHASE_INC_BITS-1:0] inc_act  [CHANNELS];
    logic [PHASE_INC_BITS-1:0] inc_pend [CHANNELS];
    logic [AMP_BITS-1:0]       amp      [CHANNELS];
    logic [CH_BITS-1:0]        slot;
    logic [ADDR_WIDTH-1:0]     addr_r;
    logic [VLEN-1:0]           valid_p;
    logic [MLEN-1:0]           wrap_p;
    logic [CH_BITS-1:0]        ch_p     [MLEN];

    logic signed [DATA_WIDTH-1:0] rom_sin, rom_cos;

    logic [SUM_W-1:0]         sum_c;
    logic                     promote_c;
    logic                     cfg_ok_c;
    logic signed [AMP_BITS:0] amp_s_c;
    logic signed [PROD_W-1:0] sin_prod_c, cos_prod_c;

    assign sum_c      = {1'b0, phase[slot]} + SUM_W'(inc_act[slot]);
    assign promote_c  = sum_c[PHASE_BITS] || (inc_act[slot] == '0);
    assign cfg_ok_c   = 32'(CFG_CH) < CHANNELS;
    assign amp_s_c    = $signed({1'b0, amp[ch_p[MLEN-1]]});
    assign sin_prod_c = PROD_W'(rom_sin) * PROD_W'(amp_s_c);
    assign cos_prod_c = PROD_W'(rom_cos) * PROD_W'(amp_s_c);

    sin_cos_rom #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_rom (
        .CLK  (CLK),
        .RESET(RESET),
        .CE   (CE),
        .ADDR (addr_r),
        .SIN  (rom_sin),
        .COS  (rom_cos)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                phase[i]    <= '0;
                inc_act[i]  <= '0;
                inc_pend[i] <= '0;
                amp[i]      <= '0;
            end
            for (int i = 0; i < int'(MLEN); i++) begin
                ch_p[i] <= '0;
            end
            slot      <= '0;
            addr_r    <= '0;
            valid_p   <= '0;
            wrap_p    <= '0;
            SIN_OUT   <= '0;
            COS_OUT   <= '0;
            OUT_CH    <= '0;
            OUT_VALID <= 1'b0;
            OUT_WRAP  <= 1'b0;
        end else if (CE) begin
            if (SYNC) begin
                for (int i = 0; i < int'(CHANNELS); i++) begin
                    phase[i]   <= '0;
                    inc_act[i] <= inc_pend[i];
                end
                // A write in the SYNC cycle goes straight to the active rate.
                if (CFG_INC_WE && cfg_ok_c) begin
                    inc_act[CFG_CH] <= CFG_INC;
                end
                slot    <= '0;
                valid_p <= '0;
            end else begin
                phase[slot] <= sum_c[PHASE_BITS-1:0];
                // Promotion reads the pending value from before any same-cycle write.
                if (promote_c) begin
                    inc_act[slot] <= inc_pend[slot];
                end
                slot    <= (slot == CH_BITS'(CHANNELS - 1)) ? '0 : slot + 1'b1;
                addr_r  <= sum_c[PHASE_BITS-1 -: ADDR_WIDTH];
                valid_p <= {valid_p[VLEN-2:0], 1'b1};
                wrap_p  <= {wrap_p[MLEN-2:0], sum_c[PHASE_BITS]};
                ch_p[0] <= slot;
                for (int i = 1; i < int'(MLEN); i++) begin
                    ch_p[i] <= ch_p[i-1];
                end
            end
            if (CFG_INC_WE && cfg_ok_c) begin
                inc_pend[CFG_CH] <= CFG_INC;
            end
            if (CFG_AMP_WE && cfg_ok_c) begin
                amp[CFG_CH] <= CFG_AMP;
            end
            if (!SYNC && valid_p[VLEN-1]) begin
                SIN_OUT   <= DATA_WIDTH'(sin_prod_c >>> AMP_BITS);
                COS_OUT   <= DATA_WIDTH'(cos_prod_c >>> AMP_BITS);
                OUT_CH    <= ch_p[MLEN-1];
                OUT_WRAP  <= wrap_p[MLEN-1];
                OUT_VALID <= 1'b1;
            end else begin
                SIN_OUT   <= '0;
                COS_OUT   <= '0;
                OUT_CH    <= '0;
                OUT_WRAP  <= 1'b0;
                OUT_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sin_cos_dco_mc.sv
// Randomized bench for sin_cos_dco_mc against a sample-level reference model.
module tb_sin_cos_dco_mc;

    localparam int PB   = 32;
    localparam int IB   = 28;
    localparam int DW   = 13;
    localparam int AW   = 12;
    localparam int NCH  = 4;
    localparam int AB   = 8;
    localparam int LAT  = 6;
    localparam real PI  = 3.14159265358979323846;
    localparam real PEAK = 4095.0;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ce = 1'b0;
    logic [1:0] cfg_ch = '0;
    logic [IB-1:0] cfg_inc = '0;
    logic cfg_inc_we = 1'b0;
    logic [AB-1:0] cfg_amp = '0;
    logic cfg_amp_we = 1'b0;
    logic sync = 1'b0;
    logic signed [DW-1:0] sin_out, cos_out;
    logic [1:0] out_ch;
    logic out_valid, out_wrap;

    always #5 clk = ~clk;

    sin_cos_dco_mc dut (
        .CLK       (clk),
        .RESET     (reset),
        .CE        (ce),
        .CFG_CH    (cfg_ch),
        .CFG_INC   (cfg_inc),
        .CFG_INC_WE(cfg_inc_we),
        .CFG_AMP   (cfg_amp),
        .CFG_AMP_WE(cfg_amp_we),
        .SYNC      (sync),
        .SIN_OUT   (sin_out),
        .COS_OUT   (cos_out),
        .OUT_CH    (out_ch),
        .OUT_VALID (out_valid),
        .OUT_WRAP  (out_wrap)
    );

    typedef struct {
        bit valid;
        int ch;
        int addr;
        bit wrap;
    } samp_t;

    longint unsigned m_phase [NCH];
    longint unsigned m_act   [NCH];
    longint unsigned m_pend  [NCH];
    int              m_amp   [NCH];
    int              m_slot;
    samp_t           m_q [$];
    int exp_sin, exp_cos, exp_ch, exp_wrap, exp_valid;
    int n_checks = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int round_sym(input real v);
        return (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(-v + 0.5);
    endfunction

    function automatic int ref_sin(input int a);
        return round_sym(PEAK * $sin(2.0 * PI * real'(a) / real'(1 << AW)));
    endfunction

    function automatic int ref_cos(input int a);
        return round_sym(PEAK * $cos(2.0 * PI * real'(a) / real'(1 << AW)));
    endfunction

    function automatic int scale(input int t, input int a);
        int p;
        p = t * a;
        return p >>> AB;
    endfunction

    function automatic void flush_model();
        samp_t e;
        e = '{valid: 1'b0, ch: 0, addr: 0, wrap: 1'b0};
        m_q = {};
        for (int i = 0; i < LAT - 1; i++) m_q.push_back(e);
        exp_sin = 0; exp_cos = 0; exp_ch = 0; exp_wrap = 0; exp_valid = 0;
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < NCH; c++) begin
            m_phase[c] = 0; m_act[c] = 0; m_pend[c] = 0; m_amp[c] = 0;
        end
        m_slot = 0;
        flush_model();
    endfunction

    // One clock edge with CE=1: emit the sample produced LAT edges ago, then advance.
    function automatic void model_edge();
        samp_t e;
        longint unsigned sum;
        bit w;
        int c;
        if (!ce) return;
        e = m_q.pop_front();
        if (e.valid) begin
            exp_sin   = scale(ref_sin(e.addr), m_amp[e.ch]);
            exp_cos   = scale(ref_cos(e.addr), m_amp[e.ch]);
            exp_ch    = e.ch;
            exp_wrap  = e.wrap;
            exp_valid = 1;
        end else begin
            exp_sin = 0; exp_cos = 0; exp_ch = 0; exp_wrap = 0; exp_valid = 0;
        end
        if (sync) begin
            for (int i = 0; i < NCH; i++) begin
                m_phase[i] = 0;
                m_act[i]   = m_pend[i];
            end
            if (cfg_inc_we) m_act[cfg_ch] = cfg_inc;
            m_slot = 0;
            flush_model();
        end else begin
            c = m_slot;
            sum = m_phase[c] + m_act[c];
            w = (sum >= (64'd1 << PB));
            m_phase[c] = sum % (64'd1 << PB);
            if (w || m_act[c] == 0) m_act[c] = m_pend[c];
            m_q.push_back('{valid: 1'b1, ch: c, addr: int'(m_phase[c] >> (PB - AW)), wrap: w});
            m_slot = (m_slot + 1) % NCH;
        end
        if (cfg_inc_we) m_pend[cfg_ch] = cfg_inc;
        if (cfg_amp_we) m_amp[cfg_ch] = int'(cfg_amp);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_edge();
        #1;
        check_eq("out_valid", out_valid, exp_valid);
        check_eq("sin_out", sin_out, exp_sin);
        check_eq("cos_out", cos_out, exp_cos);
        check_eq("out_ch", out_ch, exp_ch);
        check_eq("out_wrap", out_wrap, exp_wrap);
    endtask

    task automatic idle();
        reset = 1'b0; ce = 1'b1; sync = 1'b0;
        cfg_inc_we = 1'b0; cfg_amp_we = 1'b0;
    endtask

    task automatic write_ch(input int ch, input int inc, input int amp);
        cfg_ch = 2'(ch);
        cfg_inc = IB'(inc);
        cfg_inc_we = 1'b1;
        cfg_amp = AB'(amp);
        cfg_amp_we = 1'b1;
    endtask

    initial begin
        bit found;
        model_reset();
        reset = 1'b1;
        repeat (3) tick();

        // ch0 slow ramp at full amplitude: first ch0 sample is phase 0.
        idle();
        write_ch(0, 32'h0010_0000, 255);
        tick();
        idle();
        found = 1'b0;
        for (int n = 0; n < 20 && !found; n++) begin
            tick();
            if (out_valid && out_ch == 2'd0) begin
                found = 1'b1;
                check_eq("first_cos_max", cos_out, 4079);
                check_eq("first_sin_zero", sin_out, 0);
            end
        end
        check_eq("first_ch0_seen", found, 1);
        repeat (40) tick();

        // ch1 fast rate, then a mid-run rate change taking effect on wrap.
        write_ch(1, 32'h0800_0000, 200);
        tick();
        idle();
        repeat (150) tick();
        cfg_ch = 2'd1; cfg_inc = IB'(32'h0400_0000); cfg_inc_we = 1'b1;
        tick();
        idle();
        repeat (300) tick();

        // All channels running, then a SYNC pulse.
        write_ch(2, 32'h0123_4567, 128);
        tick();
        write_ch(3, 32'h0FFF_FFFF, 77);
        tick();
        idle();
        repeat (60) tick();
        sync = 1'b1;
        tick();
        idle();
        repeat (30) tick();

        // SYNC together with a write promotes the new rate immediately.
        sync = 1'b1;
        cfg_ch = 2'd2; cfg_inc = IB'(32'h0200_0000); cfg_inc_we = 1'b1;
        tick();
        idle();
        repeat (30) tick();

        // Reset in the middle of the stream with writes pending.
        cfg_ch = 2'd0; cfg_inc = IB'(32'h0ABC_0000); cfg_inc_we = 1'b1;
        tick();
        reset = 1'b1;
        cfg_inc_we = 1'b1; cfg_amp_we = 1'b1; sync = 1'b1;
        tick();
        idle();
        repeat (20) tick();

        // Random traffic with CE gaps, writes, occasional SYNC and RESET.
        for (int n = 0; n < 4000; n++) begin
            ce         = ($urandom_range(0, 3) != 0);
            sync       = ($urandom_range(0, 199) == 0);
            reset      = ($urandom_range(0, 799) == 0);
            cfg_inc_we = ($urandom_range(0, 9) == 0);
            cfg_amp_we = ($urandom_range(0, 19) == 0);
            cfg_ch     = 2'($urandom_range(0, NCH - 1));
            cfg_inc    = IB'($urandom >> $urandom_range(4, 12));
            cfg_amp    = AB'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
